// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared PWM timebase constants, leg state encoding and duty clamp helper
package esc_pkg;

    localparam int PWM_TICKS = 4096;
    localparam int CTR_W     = 12;

    typedef enum logic [2:0] {
        SAFE    = 3'd0,
        LO_ON   = 3'd1,
        DT_RISE = 3'd2,
        HI_ON   = 3'd3,
        DT_FALL = 3'd4
    } leg_st_t;

    // Saturate a duty request so the high side never exceeds dmax ticks.
    function automatic logic [CTR_W-1:0] clamp_duty(input logic [CTR_W-1:0] d,
                                                    input logic [CTR_W-1:0] dmax);
        return (d > dmax) ? dmax : d;
    endfunction

endpackage

// File: rtl/pwm_leg_dt.sv
// rtl/pwm_leg_dt.sv - one half-bridge leg FSM with dead-time counter and registered gate drives
module pwm_leg_dt
    import esc_pkg::*;
#(
    parameter int DEADTIME = 8
) (
    input  logic clk_ctrl,
    input  logic rst_ctrl,
    input  logic cmd,
    input  logic kill,
    output logic gate_h,
    output logic gate_l
);

    localparam logic [7:0] DT_LOAD = 8'(DEADTIME);

    leg_st_t    state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gate_h_q, gate_l_q;

    // Next-state: kill wins over everything; dead intervals last DT_LOAD cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill) begin
            state_d = SAFE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SAFE: begin
                    state_d = DT_FALL;
                    cnt_d   = DT_LOAD;
                end
                LO_ON: begin
                    if (cmd) begin
                        state_d = DT_RISE;
                        cnt_d   = DT_LOAD;
                    end
                end
                DT_RISE: begin
                    if (!cmd) begin
                        // high side never turned on, so the low side may return at once
                        state_d = LO_ON;
                        cnt_d   = '0;
                    end else if (cnt_q <= 8'd1) begin
                        state_d = HI_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                HI_ON: begin
                    if (!cmd) begin
                        state_d = DT_FALL;
                        cnt_d   = DT_LOAD;
                    end
                end
                DT_FALL: begin
                    // always completes, even if cmd rose again meanwhile
                    if (cnt_q <= 8'd1) begin
                        state_d = LO_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = SAFE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register plus registered gate decode of the next state.
    always_ff @(posedge clk_ctrl) begin
        if (rst_ctrl) begin
            state_q  <= SAFE;
            cnt_q    <= '0;
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gate_h_q <= (state_d == HI_ON);
            gate_l_q <= (state_d == LO_ON);
        end
    end

    assign gate_h = gate_h_q;
    assign gate_l = gate_l_q;

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - three-phase edge-aligned PWM with double-buffered duties and dead time
module pwm_gen
    import esc_pkg::*;
#(
    parameter int PWM_TICKS = esc_pkg::PWM_TICKS,
    parameter int DEADTIME  = 8,
    parameter int DUTY_MAX  = 4000
) (
    input  logic             clk_ctrl,
    input  logic             rst_ctrl,
    input  logic [CTR_W-1:0] pwm_ctr,
    input  logic             pwm_ctr_en,
    input  logic             fault,
    input  logic [CTR_W-1:0] duty_a,
    input  logic [CTR_W-1:0] duty_b,
    input  logic [CTR_W-1:0] duty_c,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             gate_ah,
    output logic             gate_al,
    output logic             gate_bh,
    output logic             gate_bl,
    output logic             gate_ch,
    output logic             gate_cl,
    output logic             duty_applied,
    output logic             stale_period
);

    localparam logic [CTR_W-1:0] DMAX     = CTR_W'(DUTY_MAX);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(PWM_TICKS - 1);

    logic [CTR_W-1:0]            ctr_q;
    logic                        en_q;
    logic                        pend_full_q, pend_full_d;
    logic [2:0][CTR_W-1:0]       pend_q, pend_d;
    logic [2:0][CTR_W-1:0]       act_q, act_d;
    logic                        applied_q, stale_q;
    logic [2:0]                  cmd_q, cmd_d;
    logic [2:0][CTR_W-1:0]       duty_in;
    logic                        xfer;
    logic                        ps;
    logic                        kill;
    logic [2:0]                  gate_h, gate_l;

    assign duty_in    = {duty_c, duty_b, duty_a};
    assign duty_ready = !pend_full_q;
    assign xfer       = duty_valid && duty_ready;
    assign kill       = fault || !pwm_ctr_en;

    // Period start: counter wrapped to 0 from a nonzero count, or timebase just armed.
    assign ps = ((pwm_ctr == '0) && (ctr_q != '0)) || (pwm_ctr_en && !en_q);

    // Pending/active buffering and per-phase compare.
    always_comb begin
        pend_full_d = pend_full_q;
        pend_d      = pend_q;
        act_d       = act_q;
        cmd_d       = '0;
        if (ps && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            for (int i = 0; i < 3; i++) begin
                pend_d[i] = clamp_duty(duty_in[i], DMAX);
            end
            pend_full_d = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            cmd_d[i] = pwm_ctr_en && (pwm_ctr < act_q[i]) && (pwm_ctr <= CTR_LAST);
        end
    end

    // Handshake, buffer, status pulse and compare registers.
    always_ff @(posedge clk_ctrl) begin
        if (rst_ctrl) begin
            ctr_q       <= '0;
            en_q        <= 1'b0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            act_q       <= '0;
            applied_q   <= 1'b0;
            stale_q     <= 1'b0;
            cmd_q       <= '0;
        end else begin
            ctr_q       <= pwm_ctr;
            en_q        <= pwm_ctr_en;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
            applied_q   <= ps && pend_full_q;
            stale_q     <= ps && !pend_full_q;
            cmd_q       <= cmd_d;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_leg
        pwm_leg_dt #(
            .DEADTIME(DEADTIME)
        ) u_leg (
            .clk_ctrl(clk_ctrl),
            .rst_ctrl(rst_ctrl),
            .cmd     (cmd_q[g]),
            .kill    (kill),
            .gate_h  (gate_h[g]),
            .gate_l  (gate_l[g])
        );
    end

    assign gate_ah      = gate_h[0];
    assign gate_al      = gate_l[0];
    assign gate_bh      = gate_h[1];
    assign gate_bl      = gate_l[1];
    assign gate_ch      = gate_h[2];
    assign gate_cl      = gate_l[2];
    assign duty_applied = applied_q;
    assign stale_period = stale_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed self-checking bench for pwm_gen
module tb_pwm_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pwm_ctr;
    logic        pwm_ctr_en;
    logic        fault;
    logic [11:0] duty_a, duty_b, duty_c;
    logic        duty_valid;
    logic        duty_ready;
    logic        gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
    logic        duty_applied, stale_period;

    int checks   = 0;
    int failures = 0;

    logic [11:0] ctr;
    logic        run;
    int j;
    int al_fall, al_rise, ah_rise, ah_fall, bl_rise;
    int ah_hi, al_lo, bc_lo, overlap, anyg, applied_at, stale_at;
    logic [5:0] gates;

    assign gates = {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl};

    always #5 clk = ~clk;

    pwm_gen #(.DEADTIME(8), .DUTY_MAX(4000)) dut (
        .clk_ctrl    (clk),
        .rst_ctrl    (rst),
        .pwm_ctr     (pwm_ctr),
        .pwm_ctr_en  (pwm_ctr_en),
        .fault       (fault),
        .duty_a      (duty_a),
        .duty_b      (duty_b),
        .duty_c      (duty_c),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .gate_ah     (gate_ah),
        .gate_al     (gate_al),
        .gate_bh     (gate_bh),
        .gate_bl     (gate_bl),
        .gate_ch     (gate_ch),
        .gate_cl     (gate_cl),
        .duty_applied(duty_applied),
        .stale_period(stale_period)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        j = 0;
        al_fall = 0; al_rise = 0; ah_rise = 0; ah_fall = 0; bl_rise = 0;
        ah_hi = 0; al_lo = 0; bc_lo = 0; overlap = 0; anyg = 0;
        applied_at = 0; stale_at = 0;
    endtask

    // One clock: sample after the edge, record events, then drive next count.
    task automatic step();
        @(posedge clk);
        #1;
        j++;
        if (al_fall == 0 && !gate_al) al_fall = j;
        if (al_fall != 0 && al_rise == 0 && gate_al) al_rise = j;
        if (ah_rise == 0 && gate_ah) ah_rise = j;
        if (ah_rise != 0 && ah_fall == 0 && !gate_ah) ah_fall = j;
        if (bl_rise == 0 && gate_bl) bl_rise = j;
        if (applied_at == 0 && duty_applied) applied_at = j;
        if (stale_at == 0 && stale_period) stale_at = j;
        ah_hi   += int'(gate_ah);
        al_lo   += int'(!gate_al);
        bc_lo   += int'(!gate_bl || !gate_cl);
        overlap += int'((gate_ah & gate_al) | (gate_bh & gate_bl) | (gate_ch & gate_cl));
        anyg    += int'(gates != 6'd0);
        if (run) ctr = ctr + 12'd1;
        pwm_ctr = ctr;
    endtask

    task automatic run_to(input int jend);
        while (j < jend) step();
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        duty_a = a; duty_b = b; duty_c = c;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int m;
        rst = 1'b1; pwm_ctr_en = 1'b0; fault = 1'b0;
        duty_a = '0; duty_b = '0; duty_c = '0; duty_valid = 1'b0;
        run = 1'b0; ctr = '0; pwm_ctr = '0;
        clr();

        // reset values
        repeat (3) step();
        chk("rst_gates", gates, 0);
        chk("rst_ready", duty_ready, 1);
        chk("rst_applied", duty_applied, 0);
        chk("rst_stale", stale_period, 0);
        rst = 1'b0;

        // disabled window with a pre-loaded duty
        clr();
        run_to(4);
        send(12'd1000, 12'd0, 12'd0);
        chk("preload_ready_low", duty_ready, 0);
        run_to(20);
        chk("disabled_gates", anyg, 0);
        chk("disabled_no_ps", stale_at + applied_at, 0);

        // enable: period A
        pwm_ctr_en = 1'b1; run = 1'b1; ctr = '0; pwm_ctr = '0;
        clr();
        run_to(4096);
        chk("en_applied", applied_at, 1);
        chk("en_stale", stale_at, 0);
        chk("en_bl_rise", bl_rise, 9);
        chk("en_overlap", overlap, 0);

        // period B: steady duty 1000
        clr();
        run_to(4096);
        chk("b_stale", stale_at, 1);
        chk("b_applied", applied_at, 0);
        chk("b_al_fall", al_fall, 2);
        chk("b_ah_rise", ah_rise, 10);
        chk("b_ah_fall", ah_fall, 1002);
        chk("b_al_rise", al_rise, 1010);
        chk("b_ah_hi", ah_hi, 992);
        chk("b_al_lo", al_lo, 1008);
        chk("b_bc_low_on", bc_lo, 0);
        chk("b_overlap", overlap, 0);

        // period C: 4095 requested on the ps cycle goes to pending only
        clr();
        send(12'd4095, 12'd0, 12'd0);
        chk("c_ready_low", duty_ready, 0);
        run_to(4096);
        chk("c_stale", stale_at, 1);
        chk("c_applied", applied_at, 0);
        chk("c_ah_fall_old", ah_fall, 1002);

        // period D: clamped to 4000
        clr();
        run_to(4096);
        chk("d_applied", applied_at, 1);
        chk("d_ah_fall_clamp", ah_fall, 4002);
        chk("d_ah_hi", ah_hi, 3992);

        // period E: 500 mid-period, then 700 blocked
        clr();
        run_to(100);
        duty_a = 12'd500; duty_valid = 1'b1;
        step();
        chk("e_ready_after_500", duty_ready, 0);
        duty_a = 12'd700;
        run_to(4096);
        chk("e_ready_blocked", duty_ready, 0);

        // period F: 500 applies, 700 accepted on the following cycle
        clr();
        step();
        chk("f_applied", applied_at, 1);
        chk("f_ready_free", duty_ready, 1);
        step();
        chk("f_700_taken", duty_ready, 0);
        duty_valid = 1'b0;
        run_to(4096);
        chk("f_stale", stale_at, 0);
        chk("f_ah_fall_500", ah_fall, 502);

        // period G: 700 applies
        clr();
        run_to(4096);
        chk("g_applied", applied_at, 1);
        chk("g_stale", stale_at, 0);
        chk("g_ah_fall_700", ah_fall, 702);

        // period H: fault while high side on
        clr();
        run_to(100);
        chk("h_ah_before_fault", gate_ah, 1);
        fault = 1'b1;
        step();
        chk("h_fault_gates_off", gates, 0);
        run_to(105);
        chk("h_fault_hold", gates, 0);
        fault = 1'b0;
        m = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (gate_al) begin
                m = k;
                break;
            end
        end
        chk("h_al_return", m, 9);
        run_to(4096);
        chk("h_overlap", overlap, 0);

        // period I: active duty preserved across fault
        clr();
        run_to(4096);
        chk("i_stale", stale_at, 1);
        chk("i_ah_fall_kept", ah_fall, 702);

        // period J: queue duty 3; period K applies it
        clr();
        send(12'd3, 12'd0, 12'd0);
        run_to(4096);
        chk("j_stale", stale_at, 1);
        clr();
        run_to(4096);
        chk("k_applied", applied_at, 1);
        chk("k_ah_never", ah_hi, 0);
        chk("k_al_fall", al_fall, 2);
        chk("k_al_rise", al_rise, 5);
        chk("k_al_lo", al_lo, 3);

        // mid-operation reset
        clr();
        run_to(50);
        send(12'd100, 12'd0, 12'd0);
        chk("mr_ready_low", duty_ready, 0);
        rst = 1'b1;
        step();
        chk("mr_ready", duty_ready, 1);
        chk("mr_gates", gates, 0);
        chk("mr_applied", duty_applied, 0);
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
